// File: rtl/fifo_rd_checker_pkg.sv
// Shared definitions for the FIFO read-side checker blocks:
// FSM state encoding and default parameter values.
package fifo_rd_checker_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 4;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_CNT_WIDTH   = 16;
    localparam bit          DEF_STOP_ON_ERR = 1'b0;
    localparam int unsigned GAP_WIDTH       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2,
        HALT = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_checker.sv
// Read-side FIFO checker: pops words at a programmable rate and verifies
// they form an incrementing sequence, tracking counts and the first mismatch.
module fifo_rd_checker
    import fifo_rd_checker_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter bit          STOP_ON_ERR = DEF_STOP_ON_ERR
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  clr,
    input  logic [GAP_WIDTH-1:0]  rd_gap,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] first_bad,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic                  busy
);

    rd_state_t             state;
    rd_state_t             state_next;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [GAP_WIDTH-1:0]  gap_cnt_next;
    logic [DATA_WIDTH-1:0] exp_val;
    logic                  pop;
    logic                  mismatch;
    logic                  addr_width_unused;

    // ADDR_WIDTH only documents the FIFO depth this checker is paired with.
    assign addr_width_unused = ADDR_WIDTH[0];

    assign rinc     = (state == READ);
    assign pop      = rinc & ~rempty;
    assign mismatch = pop & (rdata != exp_val);

    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        case (state)
            IDLE: begin
                if (enable) state_next = READ;
            end
            READ: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (mismatch && STOP_ON_ERR) begin
                    state_next = HALT;
                end else if (pop && (rd_gap != '0)) begin
                    state_next   = GAP;
                    gap_cnt_next = rd_gap;
                end
            end
            GAP: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - GAP_WIDTH'(1);
                    if (gap_cnt == GAP_WIDTH'(1)) state_next = READ;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clr) begin
            state_next   = IDLE;
            gap_cnt_next = '0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Expected value follows the last popped word, so one dropped word
    // produces exactly one error before the checker is back in step.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            exp_val   <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_bad <= '0;
            first_exp <= '0;
        end else if (clr) begin
            exp_val   <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_bad <= '0;
            first_exp <= '0;
        end else if (pop) begin
            rd_cnt  <= rd_cnt + CNT_WIDTH'(1);
            exp_val <= rdata + DATA_WIDTH'(1);
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
                if (!err) begin
                    first_bad <= rdata;
                    first_exp <= exp_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Self-checking bench for fifo_rd_checker: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_fifo_rd_checker;

    localparam int DW = 8;
    localparam int CW = 5;
    localparam bit M_STOP = 1'b0;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic [3:0]    rd_gap = '0;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic [CW-1:0] rd_cnt, err_cnt;
    logic          err;
    logic [DW-1:0] first_bad, first_exp;
    logic          busy;

    logic          h_enable = 1'b0;
    logic          h_clr = 1'b0;
    logic          h_rempty = 1'b1;
    logic [DW-1:0] h_rdata = '0;
    logic          h_rinc;
    logic [CW-1:0] h_rd_cnt, h_err_cnt;
    logic          h_err;
    logic [DW-1:0] h_first_bad, h_first_exp;
    logic          h_busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic          m_on, m_halt, m_err;
    int            m_gap;
    logic [CW-1:0] m_rd, m_ec;
    logic [DW-1:0] m_exp, m_fb, m_fe;
    logic [DW-1:0] src_word = '0;
    logic          last_rinc;
    logic [16:0]   pat;

    fifo_rd_checker #(
        .ADDR_WIDTH(4), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STOP_ON_ERR(1'b0)
    ) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .clr(clr),
        .rd_gap(rd_gap), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .rd_cnt(rd_cnt), .err_cnt(err_cnt), .err(err),
        .first_bad(first_bad), .first_exp(first_exp), .busy(busy)
    );

    fifo_rd_checker #(
        .ADDR_WIDTH(4), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STOP_ON_ERR(1'b1)
    ) u_halt (
        .rclk(rclk), .rrst_n(rrst_n), .enable(h_enable), .clr(h_clr),
        .rd_gap(4'd0), .rempty(h_rempty), .rdata(h_rdata), .rinc(h_rinc),
        .rd_cnt(h_rd_cnt), .err_cnt(h_err_cnt), .err(h_err),
        .first_bad(h_first_bad), .first_exp(h_first_exp), .busy(h_busy)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_halt = 1'b0; m_gap = 0; m_err = 1'b0;
        m_rd = '0; m_ec = '0; m_exp = '0; m_fb = '0; m_fe = '0;
    endtask

    task automatic check_outputs();
        check("rinc",      64'(rinc),      64'(m_on && !m_halt && (m_gap == 0)));
        check("busy",      64'(busy),      64'(m_on));
        check("rd_cnt",    64'(rd_cnt),    64'(m_rd));
        check("err_cnt",   64'(err_cnt),   64'(m_ec));
        check("err",       64'(err),       64'(m_err));
        check("first_bad", 64'(first_bad), 64'(m_fb));
        check("first_exp", 64'(first_exp), 64'(m_fe));
    endtask

    // One clock cycle: check at negedge, drive inputs, advance model at posedge.
    task automatic step(input logic en, input logic cl, input logic [3:0] gap, input logic empty);
        logic m_rinc, pop, mism;
        check_outputs();
        last_rinc = rinc;
        enable = en; clr = cl; rd_gap = gap; rempty = empty;
        rdata  = empty ? DW'($urandom) : src_word;
        m_rinc = m_on && !m_halt && (m_gap == 0);
        pop    = m_rinc && !empty;
        mism   = pop && (src_word != m_exp);
        @(posedge rclk);
        if (cl) begin
            model_reset();
        end else begin
            if (pop) begin
                m_rd = m_rd + CW'(1);
                if (mism) begin
                    if (m_ec != '1) m_ec = m_ec + CW'(1);
                    if (!m_err) begin m_fb = src_word; m_fe = m_exp; end
                    m_err = 1'b1;
                end
                m_exp = src_word + DW'(1);
            end
            if (!m_on) begin
                if (en) m_on = 1'b1;
            end else if (m_halt) begin
                m_halt = 1'b1;
            end else if (m_gap > 0) begin
                if (!en) begin m_on = 1'b0; m_gap = 0; end
                else m_gap = m_gap - 1;
            end else begin
                if (!en) m_on = 1'b0;
                else if (mism && M_STOP) m_halt = 1'b1;
                else if (pop && (gap != 4'd0)) m_gap = int'(gap);
            end
        end
        if (pop) src_word = src_word + DW'(1);
        @(negedge rclk);
    endtask

    initial begin
        model_reset();
        @(negedge rclk);
        @(negedge rclk);
        check_outputs();
        check("h_busy_rst", 64'(h_busy), 64'd0);
        check("h_rinc_rst", 64'(h_rinc), 64'd0);
        rrst_n = 1'b1;
        @(negedge rclk);

        // 20 back-to-back pops of 0..19
        src_word = '0;
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("b2b_rd_cnt", 64'(rd_cnt), 64'd20);
        check("b2b_err",    64'(err),    64'd0);

        // rd_gap=3 gives rinc 1,0,0,0 repeating
        step(1'b0, 1'b1, 4'd0, 1'b1);
        src_word = '0;
        pat = '0;
        step(1'b1, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 4'd3, 1'b0);
            pat = {pat[15:0], last_rinc};
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("gap_pattern", 64'(pat),    64'(17'b1_0001_0001_0001_0001));
        check("gap_rd_cnt",  64'(rd_cnt), 64'd5);

        // dropped word 3: sequence 0,1,2,4,5
        step(1'b0, 1'b1, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            src_word = (i < 3) ? DW'(i) : DW'(i + 1);
            step(1'b1, 1'b0, 4'd0, 1'b0);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("drop_err_cnt",   64'(err_cnt),   64'd1);
        check("drop_first_bad", 64'(first_bad), 64'd4);
        check("drop_first_exp", 64'(first_exp), 64'd3);
        check("drop_rd_cnt",    64'(rd_cnt),    64'd5);

        // rempty toggling: pops only when not empty
        step(1'b0, 1'b1, 4'd0, 1'b1);
        src_word = '0;
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd0, 1'(i % 2));
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("tog_rd_cnt", 64'(rd_cnt), 64'd10);
        check("tog_err",    64'(err),    64'd0);

        // data wrap 0xFF->0x00 is correct; rd_cnt wraps (262 mod 32 = 6)
        step(1'b0, 1'b1, 4'd0, 1'b1);
        src_word = '0;
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 262; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("wrap_rd_cnt", 64'(rd_cnt), 64'd6);
        check("wrap_err",    64'(err),    64'd0);

        // every pop wrong: err_cnt saturates at 31, first mismatch kept
        step(1'b0, 1'b1, 4'd0, 1'b1);
        src_word = DW'(1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0);
            src_word = src_word + DW'(1);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("sat_err_cnt",   64'(err_cnt),   64'd31);
        check("sat_rd_cnt",    64'(rd_cnt),    64'd8);
        check("sat_first_bad", 64'(first_bad), 64'd1);
        check("sat_first_exp", 64'(first_exp), 64'd0);

        // random traffic with occasional dropped words and clears
        step(1'b0, 1'b1, 4'd0, 1'b1);
        src_word = DW'(8'hF0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) src_word = src_word + DW'($urandom_range(1, 3));
            step(($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 ($urandom_range(0, 3) == 0));
        end
        step(1'b0, 1'b1, 4'd0, 1'b1);

        // async reset in GAP with err=1
        src_word = DW'(5);
        step(1'b1, 1'b0, 4'd5, 1'b0);
        step(1'b1, 1'b0, 4'd5, 1'b0);
        step(1'b1, 1'b0, 4'd5, 1'b1);
        check("gap_busy_pre", 64'(busy), 64'd1);
        check("gap_err_pre",  64'(err),  64'd1);
        check("gap_rinc_pre", 64'(rinc), 64'd0);
        #2 rrst_n = 1'b0;
        #1;
        check("arst_rinc",      64'(rinc),      64'd0);
        check("arst_busy",      64'(busy),      64'd0);
        check("arst_rd_cnt",    64'(rd_cnt),    64'd0);
        check("arst_err_cnt",   64'(err_cnt),   64'd0);
        check("arst_err",       64'(err),       64'd0);
        check("arst_first_bad", 64'(first_bad), 64'd0);
        check("arst_first_exp", 64'(first_exp), 64'd0);
        model_reset();
        enable = 1'b0; rempty = 1'b1; clr = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        check_outputs();

        // STOP_ON_ERR=1: sequence 0,7 halts, clr recovers
        h_enable = 1'b1; h_rempty = 1'b0; h_rdata = '0;
        @(negedge rclk);
        check("halt_rinc_read", 64'(h_rinc), 64'd1);
        @(negedge rclk);
        h_rdata = DW'(7);
        @(negedge rclk);
        h_rdata = DW'(8);
        repeat (3) @(negedge rclk);
        check("halt_rinc",      64'(h_rinc),      64'd0);
        check("halt_busy",      64'(h_busy),      64'd1);
        check("halt_rd_cnt",    64'(h_rd_cnt),    64'd2);
        check("halt_err_cnt",   64'(h_err_cnt),   64'd1);
        check("halt_first_bad", 64'(h_first_bad), 64'd7);
        check("halt_first_exp", 64'(h_first_exp), 64'd1);
        h_clr = 1'b1; h_enable = 1'b0;
        @(negedge rclk);
        h_clr = 1'b0;
        check("clr_busy",      64'(h_busy),      64'd0);
        check("clr_rinc",      64'(h_rinc),      64'd0);
        check("clr_rd_cnt",    64'(h_rd_cnt),    64'd0);
        check("clr_err_cnt",   64'(h_err_cnt),   64'd0);
        check("clr_err",       64'(h_err),       64'd0);
        check("clr_first_bad", 64'(h_first_bad), 64'd0);
        check("clr_first_exp", 64'(h_first_exp), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, FIFO address width (depth 16); used only for documentation and bench sizing.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, width of rd_cnt and err_cnt.
REQ-004 The block SHALL have parameter STOP_ON_ERR, default 0; 1 = halt reading on first mismatch.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: rclk  in  1  read-domain clock; rrst_n  in  1  async active-low reset.
REQ-006 The block SHALL have port enable  in  1  level; 1 = consume FIFO words.
REQ-007 The block SHALL have port clr  in  1  sync pulse; clears counters, flags and expected value.
REQ-008 The block SHALL have port rd_gap  in  4  idle cycles inserted after each pop (0 = back-to-back).
REQ-009 The block SHALL have port rempty  in  1  FIFO empty, registered in the rclk domain.
REQ-010 The block SHALL have port rdata  in  DATA_WIDTH  FIFO head word, valid in the same cycle when rempty=0.
REQ-011 The block SHALL have port rinc  out  1  read request to the FIFO.
REQ-012 The block SHALL have port rd_cnt  out  CNT_WIDTH  accepted pops, wrapping.
REQ-013 The block SHALL have port err_cnt  out  CNT_WIDTH  mismatches, saturating at all-ones.
REQ-014 The block SHALL have port err  out  1  sticky mismatch flag.
REQ-015 The block SHALL have ports first_bad and first_exp  out  DATA_WIDTH  rdata and expected value captured at the first mismatch.
REQ-016 The block SHALL have port busy  out  1  state is not IDLE.

Function
REQ-017 A pop SHALL occur on a rclk edge where rinc=1 and rempty=0; rinc=1 with rempty=1 is legal and SHALL have no effect.
REQ-018 rinc SHALL be 1 only in state READ and SHALL be a function of state only, never of rempty.
REQ-019 The FSM SHALL use states IDLE, READ, GAP, HALT; reset state is IDLE.
REQ-020 IDLE SHALL go to READ when enable=1.
REQ-021 READ SHALL go to IDLE when enable=0; any pop in that same cycle still counts.
REQ-022 READ SHALL go to HALT on a pop with mismatch when STOP_ON_ERR=1; this takes priority over the rd_gap transition.
REQ-023 Otherwise, on a pop with rd_gap!=0, READ SHALL load gap_cnt=rd_gap and go to GAP.
REQ-024 GAP SHALL decrement gap_cnt each cycle and return to READ in the cycle after gap_cnt reaches 1, giving exactly rd_gap cycles with rinc=0.
REQ-025 GAP SHALL go to IDLE when enable=0.
REQ-026 HALT SHALL be left only via clr or reset.
REQ-027 The expected value exp SHALL reset to 0.
REQ-028 On each pop, exp SHALL become rdata+1 (mod 2^DATA_WIDTH), so after a mismatch the checker resynchronises and a single dropped word counts as exactly one error.
REQ-029 A mismatch is rdata!=exp at a pop; on a mismatch err_cnt SHALL increment (saturating) and err SHALL be set.
REQ-030 On the first mismatch while err=0, first_bad/first_exp SHALL be captured; later mismatches SHALL not overwrite them.
REQ-031 rd_cnt SHALL increment on every pop and wrap from all-ones to 0.
REQ-032 Wrap of the data sequence from all-ones to 0 SHALL be treated as correct.
REQ-033 clr SHALL take priority over every other event in the same cycle: state goes to IDLE, and exp, rd_cnt, err_cnt, err, first_bad, first_exp go to 0; a pop coincident with clr SHALL be discarded.
REQ-034 Changes to rd_gap SHALL take effect at the next pop only.

Reset
REQ-035 Asserting rrst_n=0 SHALL asynchronously set state IDLE, rinc=0, busy=0, and set exp, gap_cnt, rd_cnt, err_cnt, err, first_bad, first_exp to 0.
REQ-036 Reset asserted mid-GAP or mid-HALT SHALL yield the same values as power-on reset.
REQ-037 Reset SHALL be released synchronously to rclk externally; the block SHALL NOT add a synchronizer.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (2-bit: IDLE, READ, GAP, HALT) and default parameter constants used by the read-side blocks.
REQ-039 No sub-module is required; all outputs SHALL be registered except rinc, which is decoded from the state register.

Verification
REQ-040 Scenario: enable=1, rd_gap=0, FIFO supplies 0..19 with no empties -> 20 consecutive pops, rd_cnt=20, err=0.
REQ-041 Scenario: rd_gap=3, words 0..4 -> rinc pattern 1,0,0,0 repeating; rd_cnt=5.
REQ-042 Scenario: sequence 0,1,2,4,5 -> err_cnt=1, first_bad=4, first_exp=3, no further errors.
REQ-043 Scenario: STOP_ON_ERR=1, sequence 0,7 -> state HALT, rinc=0, rd_cnt=2; then clr -> all counters 0 and state IDLE.
REQ-044 Scenario: rempty toggles every other cycle with rinc=1 -> pops only on rempty=0 edges; no false errors.
REQ-045 Scenario: rrst_n asserted during GAP with err=1 -> all outputs 0 immediately, without waiting for a clock edge.
